hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline sequencing controller for the RV32I core. It turns hazard conditions from decode, execute and memory into the stall, flush and redirect signals consumed by the fetch, decode and execute stages. It handles three hazard classes: load-use interlocks, outstanding data-memory requests and control-flow redirects. It also keeps a timeout watchdog and a stall-cycle counter. It sits beside the five-stage datapath, and its outputs drive the `i_stall`, `i_flush` and PC-redirect inputs of each stage.

## Interface
Parameters:
- XLEN, 32, data/PC width
- XADDR, 5, register address width
- OPLEN, 7, opcode width
- FLUSH_CYCLES, 2, cycles decode is flushed after a redirect (≥1)
- MEM_TIMEOUT, 255, maximum MEM_WAIT cycles before the watchdog releases the stall

Ports:
- i_clk  in  1  clock; all state updates on rising edge
- i_rst_n  in  1  reset; synchronous, active-low
- i_id_valid  in  1  decode holds a valid instruction
- i_id_rs1_addr, i_id_rs2_addr  in  XADDR  decode source addresses
- i_id_rs1_used, i_id_rs2_used  in  1  source actually read by the instruction
- i_ex_opcode  in  OPLEN  execute-stage opcode
- i_ex_rd_addr  in  XADDR  execute-stage destination register
- i_ex_rd_wr_en  in  1  execute-stage register write enable
- i_ex_pc_jump  in  1  execute resolved a taken branch or jump
- i_ex_pc_next  in  XLEN  target PC for that branch or jump
- i_mem_req  in  1  memory stage holds a load/store awaiting data memory
- i_mem_req_complete  in  1  data memory completes this cycle
- o_stall_if, o_stall_id, o_stall_ex  out  1  hold the stage registers
- o_flush_id, o_flush_ex  out  1  replace the stage output with a bubble
- o_pc_redirect  out  1  fetch loads o_pc_target
- o_pc_target  out  XLEN  redirect target
- o_mem_timeout  out  1  sticky watchdog error flag
- o_stall_count  out  32  saturating count of cycles with o_stall_if=1
- o_state  out  2  current FSM state (debug)

## Operation
States: RUN=0, MEM_WAIT=2, REDIRECT=3. Encoding 1 is reserved; an illegal state goes to RUN.

Terms used below:
- mem_block = i_mem_req & ~i_mem_req_complete
- load_use = (i_ex_opcode==L_OP) & i_ex_rd_wr_en & (i_ex_rd_addr!=0) & i_id_valid & ((i_id_rs1_used & rs1==rd) | (i_id_rs2_used & rs2==rd))

RUN, evaluated in priority order:
1. If mem_block: assert o_stall_if, o_stall_id and o_stall_ex. Next state is MEM_WAIT, with wait_cnt=1.
2. Else if i_ex_pc_jump: assert o_pc_redirect, o_pc_target=i_ex_pc_next, o_flush_id and o_flush_ex. If FLUSH_CYCLES>1, next state is REDIRECT with flush_cnt=FLUSH_CYCLES-1; otherwise stay in RUN.
3. Else if load_use: assert o_stall_if and o_stall_id, plus o_flush_ex, which inserts one bubble. Stay in RUN; the forwarding path resolves the hazard on the next cycle.
4. Else: all outputs are 0.

MEM_WAIT:
- If i_mem_req_complete: no stall this cycle; next state is RUN.
- Else if wait_cnt==MEM_TIMEOUT: set o_mem_timeout, release the stall, next state is RUN.
- Else: stall all three stages and increment wait_cnt.
- i_ex_pc_jump and load_use are ignored in this state, because execute is frozen.

REDIRECT:
- Assert o_flush_id; o_pc_redirect=0.
- Decrement flush_cnt. Return to RUN when flush_cnt reaches 1.
- A new i_ex_pc_jump restarts the redirect: it re-issues o_pc_redirect with the new target and reloads flush_cnt. The newer redirect wins.
- mem_block takes priority: go to MEM_WAIT. The remaining flush count is discarded; execute is already a bubble.
- load_use is ignored in this state.

Counters and flags:
- o_stall_count increments every cycle o_stall_if=1 and saturates at 2^32-1.
- o_mem_timeout clears only on reset.

## Timing
- All outputs except o_stall_count, o_mem_timeout and o_state are combinational (Mealy) from the current state and inputs. They take effect at the same rising edge as the stages' own registers, so there is zero added latency.
- State, wait_cnt, flush_cnt, o_stall_count and o_mem_timeout are registered.
- While i_rst_n=0 all outputs are forced to 0. At the first edge with i_rst_n=0, the state goes to RUN and all counters and flags clear. This holds mid-MEM_WAIT or mid-REDIRECT.
- A load-use stall lasts exactly 1 cycle.
- A memory stall lasts until the cycle in which i_mem_req_complete=1, or at most MEM_TIMEOUT cycles.
- If i_mem_req and i_mem_req_complete are both 1 in RUN, there is no stall.

## Structure
- Use opcode constants (L_OP, etc.) and XLEN/XADDR/OPLEN from the shared `header.vh`. Add the state encodings HC_RUN, HC_MEM_WAIT and HC_REDIRECT there.
- One sub-module, `hazard_detect`, computes load_use combinationally. The FSM, counters and output decode live in `hazard_ctrl`.

## Test plan
- **Load-use.** Stimulus: EX=L_OP with rd=5 and wr_en=1; ID valid with rs1=5 and rs1_used=1. Required: same cycle, o_stall_if=o_stall_id=o_flush_ex=1; next cycle all 0; o_stall_count=1. Repeat with rd=0: no stall.
- **Memory wait.** Stimulus: i_mem_req=1 for 4 cycles, with complete on the 4th. Required: stalls asserted for 3 cycles, o_state=2 during the wait, RUN after complete, o_stall_count=3.
- **Watchdog.** Stimulus: MEM_TIMEOUT=8, i_mem_req held at 1 and never completing. Required: stall released after 8 cycles, o_mem_timeout=1 and sticky; it clears only on reset.
- **Redirect.** Stimulus: FLUSH_CYCLES=2, i_ex_pc_jump=1 with i_ex_pc_next=0x0000_0100. Required: one cycle with o_pc_redirect=1, target 0x100 and both flushes; then one cycle with o_flush_id only; then RUN.
- **Priority.** Stimulus: mem_block, jump and load_use all true in the same cycle. Required: stall only, no redirect. A jump arriving during REDIRECT re-issues the redirect with the new target.
- **Reset.** Stimulus: i_rst_n=0 asserted during MEM_WAIT. Required: all outputs 0, next state RUN, counters cleared.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared RV32I constants, controller state encoding and the stage-control bundle.
// Pure declarations: no latency, no flow control.
package hazard_ctrl_pkg;

    localparam int XLEN  = 32;
    localparam int XADDR = 5;
    localparam int OPLEN = 7;

    localparam logic [OPLEN-1:0] L_OP     = 7'b0000011;
    localparam logic [OPLEN-1:0] S_OP     = 7'b0100011;
    localparam logic [OPLEN-1:0] B_OP     = 7'b1100011;
    localparam logic [OPLEN-1:0] JAL_OP   = 7'b1101111;
    localparam logic [OPLEN-1:0] JALR_OP  = 7'b1100111;
    localparam logic [OPLEN-1:0] I_OP     = 7'b0010011;
    localparam logic [OPLEN-1:0] R_OP     = 7'b0110011;
    localparam logic [OPLEN-1:0] LUI_OP   = 7'b0110111;
    localparam logic [OPLEN-1:0] AUIPC_OP = 7'b0010111;

    // Encoding 1 is reserved and treated as illegal.
    typedef enum logic [1:0] {
        HC_RUN      = 2'd0,
        HC_RSVD     = 2'd1,
        HC_MEM_WAIT = 2'd2,
        HC_REDIRECT = 2'd3
    } hc_state_e;

    typedef struct packed {
        logic stall_if;
        logic stall_id;
        logic stall_ex;
        logic flush_id;
        logic flush_ex;
        logic pc_redirect;
    } hc_ctrl_t;

    localparam hc_ctrl_t CTRL_NONE      = 6'b000000;
    localparam hc_ctrl_t CTRL_MEM_STALL = 6'b111000;
    localparam hc_ctrl_t CTRL_LOAD_USE  = 6'b110010;
    localparam hc_ctrl_t CTRL_REDIRECT  = 6'b000111;
    localparam hc_ctrl_t CTRL_FLUSH_ID  = 6'b000100;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Hazard sources from ID/EX/MEM and the stall/flush/redirect controls returned to the stages.
// Plain wires: no latency of its own; stalls are the only backpressure carried.
interface hazard_ctrl_if;
    import hazard_ctrl_pkg::*;

    logic             id_valid;
    logic [XADDR-1:0] id_rs1_addr;
    logic [XADDR-1:0] id_rs2_addr;
    logic             id_rs1_used;
    logic             id_rs2_used;
    logic [OPLEN-1:0] ex_opcode;
    logic [XADDR-1:0] ex_rd_addr;
    logic             ex_rd_wr_en;
    logic             ex_pc_jump;
    logic [XLEN-1:0]  ex_pc_next;
    logic             mem_req;
    logic             mem_req_complete;

    logic             stall_if;
    logic             stall_id;
    logic             stall_ex;
    logic             flush_id;
    logic             flush_ex;
    logic             pc_redirect;
    logic [XLEN-1:0]  pc_target;
    logic             mem_timeout;
    logic [31:0]      stall_count;
    logic [1:0]       state;

    modport master (
        output id_valid, id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used,
               ex_opcode, ex_rd_addr, ex_rd_wr_en, ex_pc_jump, ex_pc_next,
               mem_req, mem_req_complete,
        input  stall_if, stall_id, stall_ex, flush_id, flush_ex, pc_redirect,
               pc_target, mem_timeout, stall_count, state
    );

    modport slave (
        input  id_valid, id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used,
               ex_opcode, ex_rd_addr, ex_rd_wr_en, ex_pc_jump, ex_pc_next,
               mem_req, mem_req_complete,
        output stall_if, stall_id, stall_ex, flush_id, flush_ex, pc_redirect,
               pc_target, mem_timeout, stall_count, state
    );

endinterface

// File: rtl/hazard_detect.sv
// Load-use detector: a load in EX writes a register that the instruction in ID reads.
// Purely combinational, zero latency; no flow control.
module hazard_detect
    import hazard_ctrl_pkg::*;
(
    input  logic             id_valid,
    input  logic [XADDR-1:0] id_rs1_addr,
    input  logic [XADDR-1:0] id_rs2_addr,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic [OPLEN-1:0] ex_opcode,
    input  logic [XADDR-1:0] ex_rd_addr,
    input  logic             ex_rd_wr_en,
    output logic             load_use
);

    logic rs1_hit;
    logic rs2_hit;
    logic ex_load_wr;

    assign rs1_hit    = id_rs1_used && (id_rs1_addr == ex_rd_addr);
    assign rs2_hit    = id_rs2_used && (id_rs2_addr == ex_rd_addr);
    // x0 is never a real producer, so a load targeting it cannot create a hazard.
    assign ex_load_wr = (ex_opcode == L_OP) && ex_rd_wr_en && (ex_rd_addr != '0);
    assign load_use   = ex_load_wr && id_valid && (rs1_hit || rs2_hit);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer: load-use interlock, data-memory wait with watchdog, redirect flushing.
// Controls are Mealy (zero latency); stalls are the backpressure applied to IF/ID/EX.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int MEM_TIMEOUT  = 255
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    hazard_ctrl_if.slave hz
);

    localparam int WCW = (MEM_TIMEOUT  > 1) ? $clog2(MEM_TIMEOUT + 1)  : 1;
    localparam int FCW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES + 1) : 1;
    localparam logic [WCW-1:0] WAIT_MAX     = WCW'(MEM_TIMEOUT);
    localparam logic [FCW-1:0] FLUSH_RELOAD = FCW'(FLUSH_CYCLES - 1);
    localparam logic [FCW-1:0] FLUSH_LAST   = FCW'(1);
    localparam logic [WCW-1:0] WAIT_FIRST   = WCW'(1);

    hc_state_e       state_q, state_d;
    logic [WCW-1:0]  wait_q, wait_d;
    logic [FCW-1:0]  flush_q, flush_d;
    logic            timeout_q, timeout_set;
    logic [31:0]     stall_cnt_q;
    hc_ctrl_t        ctrl;
    logic [XLEN-1:0] target;
    logic            load_use;
    logic            mem_block;

    assign mem_block = hz.mem_req && !hz.mem_req_complete;

    hazard_detect u_detect (
        .id_valid    (hz.id_valid),
        .id_rs1_addr (hz.id_rs1_addr),
        .id_rs2_addr (hz.id_rs2_addr),
        .id_rs1_used (hz.id_rs1_used),
        .id_rs2_used (hz.id_rs2_used),
        .ex_opcode   (hz.ex_opcode),
        .ex_rd_addr  (hz.ex_rd_addr),
        .ex_rd_wr_en (hz.ex_rd_wr_en),
        .load_use    (load_use)
    );

    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        flush_d     = flush_q;
        ctrl        = CTRL_NONE;
        target      = '0;
        timeout_set = 1'b0;
        case (state_q)
            HC_RUN: begin
                if (mem_block) begin
                    ctrl    = CTRL_MEM_STALL;
                    state_d = HC_MEM_WAIT;
                    wait_d  = WAIT_FIRST;
                end else if (hz.ex_pc_jump) begin
                    ctrl   = CTRL_REDIRECT;
                    target = hz.ex_pc_next;
                    if (FLUSH_CYCLES > 1) begin
                        state_d = HC_REDIRECT;
                        flush_d = FLUSH_RELOAD;
                    end
                end else if (load_use) begin
                    ctrl = CTRL_LOAD_USE;
                end
            end
            HC_MEM_WAIT: begin
                // EX is frozen here, so jumps and load-use are not acted on.
                if (hz.mem_req_complete) begin
                    state_d = HC_RUN;
                end else if (wait_q == WAIT_MAX) begin
                    timeout_set = 1'b1;
                    state_d     = HC_RUN;
                end else begin
                    ctrl   = CTRL_MEM_STALL;
                    wait_d = wait_q + 1'b1;
                end
            end
            HC_REDIRECT: begin
                if (mem_block) begin
                    // Remaining flushes are dropped: EX already holds a bubble.
                    ctrl    = CTRL_MEM_STALL;
                    state_d = HC_MEM_WAIT;
                    wait_d  = WAIT_FIRST;
                end else if (hz.ex_pc_jump) begin
                    ctrl    = CTRL_REDIRECT;
                    target  = hz.ex_pc_next;
                    flush_d = FLUSH_RELOAD;
                    state_d = (FLUSH_CYCLES > 1) ? HC_REDIRECT : HC_RUN;
                end else begin
                    ctrl = CTRL_FLUSH_ID;
                    if (flush_q <= FLUSH_LAST) begin
                        state_d = HC_RUN;
                    end else begin
                        flush_d = flush_q - 1'b1;
                    end
                end
            end
            default: begin
                state_d = HC_RUN;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q     <= HC_RUN;
            wait_q      <= '0;
            flush_q     <= '0;
            timeout_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            flush_q   <= flush_d;
            timeout_q <= timeout_q || timeout_set;
            if (ctrl.stall_if && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    // Reset masks every output, including the registered ones, before the first edge.
    assign hz.stall_if    = i_rst_n && ctrl.stall_if;
    assign hz.stall_id    = i_rst_n && ctrl.stall_id;
    assign hz.stall_ex    = i_rst_n && ctrl.stall_ex;
    assign hz.flush_id    = i_rst_n && ctrl.flush_id;
    assign hz.flush_ex    = i_rst_n && ctrl.flush_ex;
    assign hz.pc_redirect = i_rst_n && ctrl.pc_redirect;
    assign hz.pc_target   = i_rst_n ? target : '0;
    assign hz.mem_timeout = i_rst_n && timeout_q;
    assign hz.stall_count = i_rst_n ? stall_cnt_q : '0;
    assign hz.state       = i_rst_n ? state_q : 2'd0;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: vector table for single-cycle decisions plus multi-cycle sequences.
module tb_hazard_ctrl;
    import hazard_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    hazard_ctrl_if hz ();

    hazard_ctrl #(.FLUSH_CYCLES(2), .MEM_TIMEOUT(8)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .hz      (hz.slave)
    );

    typedef struct {
        logic        id_valid;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        u1;
        logic        u2;
        logic [6:0]  op;
        logic [4:0]  rd;
        logic        we;
        logic        jump;
        logic [31:0] pc;
        logic        mreq;
        logic        mcmp;
        logic [5:0]  exp_ctrl;
        logic [31:0] exp_tgt;
        logic [1:0]  exp_state;
    } vec_t;

    vec_t vecs[13];

    function automatic vec_t mk(logic v, logic [4:0] r1, logic [4:0] r2, logic a, logic b,
                                logic [6:0] op, logic [4:0] rd, logic we, logic j,
                                logic [31:0] pc, logic mr, logic mc, logic [5:0] ec,
                                logic [31:0] et, logic [1:0] es);
        vec_t t;
        t.id_valid = v;  t.rs1 = r1; t.rs2 = r2; t.u1 = a; t.u2 = b;
        t.op = op; t.rd = rd; t.we = we; t.jump = j; t.pc = pc;
        t.mreq = mr; t.mcmp = mc; t.exp_ctrl = ec; t.exp_tgt = et; t.exp_state = es;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [5:0] ctrl_now();
        return {hz.stall_if, hz.stall_id, hz.stall_ex, hz.flush_id, hz.flush_ex, hz.pc_redirect};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        hz.id_valid = 0; hz.id_rs1_addr = 0; hz.id_rs2_addr = 0;
        hz.id_rs1_used = 0; hz.id_rs2_used = 0; hz.ex_opcode = 0;
        hz.ex_rd_addr = 0; hz.ex_rd_wr_en = 0; hz.ex_pc_jump = 0;
        hz.ex_pc_next = 0; hz.mem_req = 0; hz.mem_req_complete = 0;
    endtask

    task automatic do_reset();
        clr();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic drive(input vec_t v);
        hz.id_valid = v.id_valid; hz.id_rs1_addr = v.rs1; hz.id_rs2_addr = v.rs2;
        hz.id_rs1_used = v.u1; hz.id_rs2_used = v.u2; hz.ex_opcode = v.op;
        hz.ex_rd_addr = v.rd; hz.ex_rd_wr_en = v.we; hz.ex_pc_jump = v.jump;
        hz.ex_pc_next = v.pc; hz.mem_req = v.mreq; hz.mem_req_complete = v.mcmp;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        //               v  rs1 rs2 u1 u2 op      rd we j  pc           mr mc ctrl       tgt          state
        vecs[0]  = mk(0, 0,  0,  0, 0, 7'd0,  0, 0, 0, 32'h0,      0, 0, 6'b000000, 32'h0,      2'd0);
        vecs[1]  = mk(1, 5,  0,  1, 0, L_OP,  5, 1, 0, 32'h0,      0, 0, 6'b110010, 32'h0,      2'd0);
        vecs[2]  = mk(1, 3,  7,  0, 1, L_OP,  7, 1, 0, 32'h0,      0, 0, 6'b110010, 32'h0,      2'd0);
        vecs[3]  = mk(1, 0,  0,  1, 1, L_OP,  0, 1, 0, 32'h0,      0, 0, 6'b000000, 32'h0,      2'd0);
        vecs[4]  = mk(1, 5,  0,  0, 0, L_OP,  5, 1, 0, 32'h0,      0, 0, 6'b000000, 32'h0,      2'd0);
        vecs[5]  = mk(1, 5,  0,  1, 0, L_OP,  5, 0, 0, 32'h0,      0, 0, 6'b000000, 32'h0,      2'd0);
        vecs[6]  = mk(1, 5,  0,  1, 0, S_OP,  5, 1, 0, 32'h0,      0, 0, 6'b000000, 32'h0,      2'd0);
        vecs[7]  = mk(0, 5,  0,  1, 0, L_OP,  5, 1, 0, 32'h0,      0, 0, 6'b000000, 32'h0,      2'd0);
        vecs[8]  = mk(0, 0,  0,  0, 0, 7'd0,  0, 0, 0, 32'h0,      1, 1, 6'b000000, 32'h0,      2'd0);
        vecs[9]  = mk(0, 0,  0,  0, 0, 7'd0,  0, 0, 0, 32'h0,      1, 0, 6'b111000, 32'h0,      2'd2);
        vecs[10] = mk(0, 0,  0,  0, 0, 7'd0,  0, 0, 1, 32'h100,    0, 0, 6'b000111, 32'h100,    2'd3);
        vecs[11] = mk(1, 9,  0,  1, 0, L_OP,  9, 1, 1, 32'hABC0,   0, 0, 6'b000111, 32'hABC0,   2'd3);
        vecs[12] = mk(1, 9,  0,  1, 0, L_OP,  9, 1, 1, 32'h200,    1, 0, 6'b111000, 32'h0,      2'd2);

        clr();
        #2;
        chk("rst_ctrl", 32'(ctrl_now()), 32'd0);
        chk("rst_state", 32'(hz.state), 32'd0);
        do_reset();
        chk("post_rst_count", hz.stall_count, 32'd0);
        chk("post_rst_timeout", 32'(hz.mem_timeout), 32'd0);

        for (int i = 0; i < 13; i++) begin
            do_reset();
            drive(vecs[i]);
            #1;
            chk($sformatf("vec%0d_ctrl", i), 32'(ctrl_now()), 32'(vecs[i].exp_ctrl));
            chk($sformatf("vec%0d_tgt", i), hz.pc_target, vecs[i].exp_tgt);
            step();
            clr();
            #1;
            chk($sformatf("vec%0d_state", i), 32'(hz.state), 32'(vecs[i].exp_state));
        end

        // Load-use: one-cycle interlock, EX becomes a bubble next cycle.
        do_reset();
        hz.ex_opcode = L_OP; hz.ex_rd_addr = 5; hz.ex_rd_wr_en = 1;
        hz.id_valid = 1; hz.id_rs1_addr = 5; hz.id_rs1_used = 1;
        #1;
        chk("lu_ctrl", 32'(ctrl_now()), 32'b110010);
        step();
        hz.ex_opcode = R_OP;
        #1;
        chk("lu_next_ctrl", 32'(ctrl_now()), 32'd0);
        chk("lu_count", hz.stall_count, 32'd1);

        // Memory wait completing on the 4th request cycle.
        do_reset();
        hz.mem_req = 1;
        #1;
        chk("mw_c1_ctrl", 32'(ctrl_now()), 32'b111000);
        chk("mw_c1_state", 32'(hz.state), 32'd0);
        for (int c = 2; c <= 3; c++) begin
            step();
            chk($sformatf("mw_c%0d_ctrl", c), 32'(ctrl_now()), 32'b111000);
            chk($sformatf("mw_c%0d_state", c), 32'(hz.state), 32'd2);
        end
        step();
        hz.mem_req_complete = 1;
        #1;
        chk("mw_c4_ctrl", 32'(ctrl_now()), 32'd0);
        step();
        clr();
        #1;
        chk("mw_end_state", 32'(hz.state), 32'd0);
        chk("mw_count", hz.stall_count, 32'd3);

        // Watchdog: request never completes.
        do_reset();
        hz.mem_req = 1;
        for (int c = 1; c <= 8; c++) begin
            #1;
            chk($sformatf("wd_c%0d_stall", c), 32'(ctrl_now()), 32'b111000);
            step();
        end
        #1;
        chk("wd_release_ctrl", 32'(ctrl_now()), 32'd0);
        chk("wd_release_flag", 32'(hz.mem_timeout), 32'd0);
        step();
        hz.mem_req = 0;
        #1;
        chk("wd_flag_set", 32'(hz.mem_timeout), 32'd1);
        chk("wd_state_run", 32'(hz.state), 32'd0);
        chk("wd_count", hz.stall_count, 32'd8);
        step(); step(); step();
        chk("wd_flag_sticky", 32'(hz.mem_timeout), 32'd1);
        do_reset();
        chk("wd_flag_cleared", 32'(hz.mem_timeout), 32'd0);

        // Redirect with two flush cycles.
        do_reset();
        hz.ex_pc_jump = 1; hz.ex_pc_next = 32'h0000_0100;
        #1;
        chk("rd_c1_ctrl", 32'(ctrl_now()), 32'b000111);
        chk("rd_c1_tgt", hz.pc_target, 32'h100);
        step();
        clr();
        #1;
        chk("rd_c2_ctrl", 32'(ctrl_now()), 32'b000100);
        chk("rd_c2_state", 32'(hz.state), 32'd3);
        step();
        chk("rd_c3_ctrl", 32'(ctrl_now()), 32'd0);
        chk("rd_c3_state", 32'(hz.state), 32'd0);

        // New jump during REDIRECT wins and reloads the flush count.
        do_reset();
        hz.ex_pc_jump = 1; hz.ex_pc_next = 32'h100;
        step();
        hz.ex_pc_next = 32'h200;
        #1;
        chk("rr_ctrl", 32'(ctrl_now()), 32'b000111);
        chk("rr_tgt", hz.pc_target, 32'h200);
        step();
        clr();
        #1;
        chk("rr_state", 32'(hz.state), 32'd3);
        chk("rr_flush_ctrl", 32'(ctrl_now()), 32'b000100);
        step();
        chk("rr_end_state", 32'(hz.state), 32'd0);

        // Memory block during REDIRECT goes straight to MEM_WAIT.
        do_reset();
        hz.ex_pc_jump = 1; hz.ex_pc_next = 32'h300;
        step();
        clr();
        hz.mem_req = 1;
        #1;
        chk("rm_ctrl", 32'(ctrl_now()), 32'b111000);
        step();
        chk("rm_state", 32'(hz.state), 32'd2);

        // Reset in the middle of MEM_WAIT.
        do_reset();
        hz.mem_req = 1;
        step(); step();
        chk("rw_pre_state", 32'(hz.state), 32'd2);
        rst_n = 1'b0;
        #1;
        chk("rw_ctrl_forced", 32'(ctrl_now()), 32'd0);
        chk("rw_state_forced", 32'(hz.state), 32'd0);
        chk("rw_count_forced", hz.stall_count, 32'd0);
        step();
        rst_n = 1'b1;
        clr();
        #1;
        chk("rw_state_run", 32'(hz.state), 32'd0);
        chk("rw_count_clr", hz.stall_count, 32'd0);
        chk("rw_ctrl_idle", 32'(ctrl_now()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
